// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
// Module      : uart_defs (package)
// Description : Shared FSM encodings and serial framing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_if
// Description : FIFO read-side bundle (pop strobe, head word, empty flag).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if #(
    parameter int Width = 32
);

    logic             Empty;
    logic [Width-1:0] Read_Data;
    logic             Read;

    // master: the FIFO providing words; slave: the transmitter popping them
    modport master (output Empty, output Read_Data, input Read);
    modport slave  (input Empty, input Read_Data, output Read);

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Counts clk cycles within one serial bit; ticks on the last.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int Clks_Per_Bit = 16
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  i_run,
    output logic o_bit_tick
);

    localparam int C_CNT_W = (Clks_Per_Bit > 1) ? $clog2(Clks_Per_Bit) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(Clks_Per_Bit - 1);

    logic [C_CNT_W-1:0] r_count;

    // Held at zero while idle so the first bit of a frame gets full length
    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_count <= '0;
        end else if (r_count == C_LAST_CNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + C_CNT_W'(1);
        end
    end

    assign o_bit_tick = i_run && (r_count == C_LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops words from a FIFO and sends them LSB byte/bit first
//               as 8N1 frames; FIFO_UART_TX_PARITY_EN adds even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import uart_defs::*;
#(
    parameter int Width        = 32,
    parameter int Clks_Per_Bit = 16
) (
    input  wire           clk,
    input  wire           reset,
    fifo_uart_tx_if.slave fifo_if,
    output logic          Tx,
    output logic          Busy,
    output logic          Word_Done
);

    localparam int C_BYTES  = Width / 8;
    localparam int C_BYTE_W = (C_BYTES > 1) ? $clog2(C_BYTES) : 1;
    localparam logic [C_BYTE_W-1:0] C_LAST_BYTE = C_BYTE_W'(C_BYTES - 1);
    localparam logic [2:0]          C_LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t         r_state;
    logic [Width-1:0]    r_shift;
    logic [2:0]          r_bit_idx;
    logic [C_BYTE_W-1:0] r_byte_idx;
    logic                r_tx;
    logic                r_busy;
    logic                r_word_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                r_parity;
`endif
    logic                w_read;
    logic                w_bit_tick;

    assign w_read       = (r_state == ST_IDLE) && !fifo_if.Empty && !reset;
    assign fifo_if.Read = w_read;
    assign Tx           = r_tx;
    assign Busy         = r_busy;
    assign Word_Done    = r_word_done;

    uart_bit_timer #(
        .Clks_Per_Bit (Clks_Per_Bit)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .i_run      (r_busy),
        .o_bit_tick (w_bit_tick)
    );

    // Tx is registered with the state, so each bit value is loaded on the
    // same edge that enters the state which owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_tx        <= STOP_BIT;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_read) begin
                        r_shift    <= fifo_if.Read_Data;
                        r_byte_idx <= '0;
                        r_tx       <= START_BIT;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        r_parity  <= r_shift[0];
`endif
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == C_LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= STOP_BIT;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
`ifdef FIFO_UART_TX_PARITY_EN
                            r_parity  <= r_parity ^ r_shift[0];
`endif
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_tx    <= STOP_BIT;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_tick) begin
                        if (r_byte_idx == C_LAST_BYTE) begin
                            r_tx        <= STOP_BIT;
                            r_busy      <= 1'b0;
                            r_word_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_tx       <= START_BIT;
                            r_byte_idx <= r_byte_idx + C_BYTE_W'(1);
                            r_state    <= ST_START;
                        end
                    end
                end
                default: begin
                    r_tx    <= STOP_BIT;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
